fifo16: RTL
===========

FIFO16 -- requirements
Module: fifo16

Interface
REQ-001 Parameter: DEPTH, default 4, number of 16-bit entries; SHALL be a power of two in 2..16.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: Reset  input  1  synchronous active-high reset.
REQ-005 Port: flush  input  1  synchronous clear of contents; no effect on storage array values.
REQ-006 Port: in_data  input  16  write data.
REQ-007 Port: in_valid  input  1  producer offers in_data.
REQ-008 Port: in_ready  output  1  FIFO can accept; equals !full.
REQ-009 Port: out_data  output  16  head entry (show-ahead); feeds downstream 16-bit buffer stage unchanged.
REQ-010 Port: out_valid  output  1  head entry valid; equals !empty.
REQ-011 Port: out_ready  input  1  consumer takes head.
REQ-012 Port: count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 Push SHALL occur exactly when in_valid && in_ready at a rising edge; entry written at wr_ptr, wr_ptr increments.
REQ-014 Pop SHALL occur exactly when out_valid && out_ready at a rising edge; rd_ptr increments.
REQ-015 Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH without extra logic.
REQ-016 count SHALL be +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-017 full = (count == DEPTH); empty = (count == 0); both derived from registered count, no combinational path from inputs to in_ready/out_valid.
REQ-018 out_data SHALL be combinational read of storage[rd_ptr]; value undefined-by-contract when out_valid=0 but SHALL not be X after reset.
REQ-019 Latency: word pushed into empty FIFO at edge N SHALL appear with out_valid=1 after edge N (no same-cycle fall-through).
REQ-020 Full FIFO: in_ready=0, in_valid ignored; simultaneous pop frees a slot, in_ready=1 the following cycle.
REQ-021 Empty FIFO: out_valid=0, out_ready ignored, count never underflows.
REQ-022 Simultaneous push+pop with 0<count<DEPTH: both occur, count unchanged, order preserved.
REQ-023 flush SHALL set wr_ptr=rd_ptr=0, count=0 at the edge; flush overrides push and pop in the same cycle (both discarded).
REQ-024 Data order SHALL be strict FIFO; no entry dropped or duplicated except by flush/Reset.

Reset
REQ-025 On Reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, all storage entries=16'h0000 (so out_data=16'h0000).
REQ-026 Reset SHALL take priority over flush, push and pop; Reset mid-stream discards all contents.
REQ-027 Reset held multiple cycles: outputs remain at reset values; first push accepted on the first edge with Reset=0.

Verification
REQ-028 Fill/drain: push 16'h1111,2222,3333,4444 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> out_data 1111,2222,3333,4444 on consecutive cycles, count 3,2,1,0.
REQ-029 Overflow: at count=4 drive in_valid=1 with 16'hDEAD, out_ready=0 -> count stays 4, DEAD never appears at output.
REQ-030 Streaming: in_valid=1, out_ready=1 continuously with incrementing data from 16'h0000 for 20 cycles -> count settles at 1, output sequence exactly matches input delayed one cycle, pointers wrap cleanly.
REQ-031 Flush collision: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-032 Reset mid-operation: count=3, Reset=1 for one edge with in_valid=1 -> count=0, out_data=16'h0000, out_valid=0; subsequent push of 16'hBEEF -> out_data=BEEF, out_valid=1 one edge later.
REQ-033 Underflow: empty FIFO, out_ready=1 for 5 cycles -> count stays 0, out_valid stays 0.

Source files
------------

// File: rtl/fifo16.sv
// fifo16: show-ahead 16-bit FIFO with valid/ready on both sides.
// Synchronous active-high Reset clears storage; flush clears only occupancy.
module fifo16 #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status comes only from the registered count, never from inputs.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
